// File: rtl/sti_rx.sv
// STI serial receiver: samples a framed bit stream, strips padding and rebuilds
// the 16-bit parallel word with a one-cycle valid strobe.
module sti_rx #(
  parameter bit CHECK_PAD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        si_data,
  input  logic        si_valid,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_fill,
  input  logic        cfg_msb,
  input  logic        cfg_low,
  output logic [15:0] po_data,
  output logic        po_valid,
  output logic        frame_err,
  output logic        pad_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t      state, state_nx;
  logic [1:0]  len_q;
  logic        fill_q, msb_q, low_q;
  logic [5:0]  cnt;
  logic [31:0] frame;

  logic        start, accept, abort, last;
  logic [1:0]  eff_len;
  logic        eff_fill, eff_msb, eff_low;
  logic [5:0]  n_bits, cnt_base, cnt_nx;
  logic [4:0]  idx;
  logic [31:0] frame_nx;
  logic [15:0] data, pad;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nx = state;
    start    = 1'b0;
    accept   = 1'b0;
    abort    = 1'b0;
    data     = '0;
    pad      = '0;

    case (state)
      IDLE: if (si_valid) begin
        start    = 1'b1;
        state_nx = RECV;
      end
      RECV: if (si_valid) begin
        accept = 1'b1;
      end else begin
        abort    = 1'b1;
        state_nx = IDLE;
      end
      DONE: if (si_valid) begin
        start    = 1'b1;
        state_nx = RECV;
      end else begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // A frame's first bit is decoded with the live config; later bits use the latched copy.
    eff_len  = start ? cfg_length : len_q;
    eff_fill = start ? cfg_fill   : fill_q;
    eff_msb  = start ? cfg_msb    : msb_q;
    eff_low  = start ? cfg_low    : low_q;

    n_bits   = ({4'd0, eff_len} + 6'd1) << 3;
    cnt_base = start ? 6'd0 : cnt;
    cnt_nx   = cnt_base + 6'd1;
    idx      = eff_msb ? 5'(n_bits - 6'd1 - cnt_base) : cnt_base[4:0];

    frame_nx = start ? '0 : frame;
    if (start || accept) frame_nx[idx] = si_data;

    last = accept && (cnt_nx == n_bits);
    if (last) state_nx = DONE;

    case (eff_len)
      2'd0: data = eff_low ? {frame_nx[7:0], 8'h00} : {8'h00, frame_nx[7:0]};
      2'd1: data = frame_nx[15:0];
      2'd2: begin
        data = eff_fill ? frame_nx[23:8] : frame_nx[15:0];
        pad  = eff_fill ? {8'h00, frame_nx[7:0]} : {8'h00, frame_nx[23:16]};
      end
      default: begin
        data = eff_fill ? frame_nx[31:16] : frame_nx[15:0];
        pad  = eff_fill ? frame_nx[15:0]  : frame_nx[31:16];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      fill_q    <= 1'b0;
      msb_q     <= 1'b0;
      low_q     <= 1'b0;
      cnt       <= '0;
      frame     <= '0;
      po_data   <= '0;
      po_valid  <= 1'b0;
      frame_err <= 1'b0;
      pad_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      po_valid  <= last;
      frame_err <= abort;
      pad_err   <= last && CHECK_PAD && (pad != 16'h0000);
      if (start) begin
        len_q  <= cfg_length;
        fill_q <= cfg_fill;
        msb_q  <= cfg_msb;
        low_q  <= cfg_low;
      end
      if (start || accept) begin
        cnt   <= cnt_nx;
        frame <= frame_nx;
      end else if (abort) begin
        cnt   <= '0;
        frame <= '0;
      end
      if (last) po_data <= data;
    end
  end

  assign busy = (state == RECV);

endmodule

// File: tb/tb_sti_rx.sv
// Self-checking bench for sti_rx: directed scenarios plus randomized frames
// checked against a payload/padding reference model.
module tb_sti_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        si_data, si_valid;
  logic [1:0]  cfg_length;
  logic        cfg_fill, cfg_msb, cfg_low;
  logic [15:0] po_data, po_data2;
  logic        po_valid, po_valid2, frame_err, frame_err2, pad_err, pad_err2, busy, busy2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sti_rx #(.CHECK_PAD(1'b1)) dut (
    .clk(clk), .reset(reset), .si_data(si_data), .si_valid(si_valid),
    .cfg_length(cfg_length), .cfg_fill(cfg_fill), .cfg_msb(cfg_msb), .cfg_low(cfg_low),
    .po_data(po_data), .po_valid(po_valid), .frame_err(frame_err), .pad_err(pad_err), .busy(busy)
  );

  sti_rx #(.CHECK_PAD(1'b0)) dut_nopad (
    .clk(clk), .reset(reset), .si_data(si_data), .si_valid(si_valid),
    .cfg_length(cfg_length), .cfg_fill(cfg_fill), .cfg_msb(cfg_msb), .cfg_low(cfg_low),
    .po_data(po_data2), .po_valid(po_valid2), .frame_err(frame_err2), .pad_err(pad_err2), .busy(busy2)
  );

  // Reference model: assemble the frame value from payload and padding.
  function automatic logic [31:0] make_frame(input logic [1:0] len, input logic fill,
                                             input logic [15:0] payload, input logic [15:0] padv);
    logic [31:0] p, q;
    p = {16'h0, payload};
    q = {16'h0, padv};
    case (len)
      2'd0:    return p % 256;
      2'd1:    return p;
      2'd2:    return fill ? (p * 256 + q % 256) : ((q % 256) * 65536 + p);
      default: return fill ? (p * 65536 + q) : (q * 65536 + p);
    endcase
  endfunction

  function automatic logic [15:0] exp_data(input logic [1:0] len, input logic low, input logic [15:0] payload);
    if (len == 2'd0) return low ? 16'((payload % 256) * 256) : 16'(payload % 256);
    return payload;
  endfunction

  function automatic logic exp_pad(input logic [1:0] len, input logic [15:0] padv);
    if (len == 2'd2) return (padv % 256) != 0;
    if (len == 2'd3) return padv != 0;
    return 1'b0;
  endfunction

  // Drives nbits of a frame; after the first bit the live cfg is scrambled to prove it is latched.
  task automatic send_frame(input logic [1:0] len, input logic fill, input logic msb, input logic low,
                            input logic [31:0] fr, input int nbits);
    int n;
    n = 8 * (int'(len) + 1);
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      si_valid = 1'b1;
      si_data  = msb ? fr[n-1-k] : fr[k];
      if (k == 0) begin
        cfg_length = len; cfg_fill = fill; cfg_msb = msb; cfg_low = low;
      end else if (k == 1) begin
        cfg_length = 2'($urandom); cfg_fill = 1'($urandom); cfg_msb = 1'($urandom); cfg_low = 1'($urandom);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    si_valid = 1'b0;
    si_data  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; si_valid = 1'b0; si_data = 1'b0;
    cfg_length = 2'd0; cfg_fill = 1'b0; cfg_msb = 1'b0; cfg_low = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({po_data, po_valid, frame_err, pad_err, busy} !== 20'h0) begin
      fails++;
      $display("FAIL reset: po_data=%h valid=%b ferr=%b perr=%b busy=%b, expected all 0",
               po_data, po_valid, frame_err, pad_err, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_byte_frames();
    send_frame(2'd0, 1'b0, 1'b1, 1'b0, 32'hA5, 8);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_in_frame: busy=%b expected 1", busy); end
    idle();
    tests++;
    if (po_valid !== 1'b1 || po_data !== 16'h00A5 || pad_err !== 1'b0) begin
      fails++;
      $display("FAIL byte_msb: valid=%b data=%h perr=%b, expected 1 00a5 0", po_valid, po_data, pad_err);
    end
    idle();
    tests++;
    if (po_valid !== 1'b0 || po_data !== 16'h00A5 || busy !== 1'b0) begin
      fails++;
      $display("FAIL byte_strobe_width: valid=%b data=%h busy=%b, expected 0 00a5 0", po_valid, po_data, busy);
    end
    send_frame(2'd0, 1'b0, 1'b0, 1'b1, 32'hA5, 8);
    idle();
    tests++;
    if (po_valid !== 1'b1 || po_data !== 16'hA500) begin
      fails++;
      $display("FAIL byte_lsb_low: valid=%b data=%h, expected 1 a500", po_valid, po_data);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] fr2;
    int t0;
    t0  = 0;
    fr2 = 32'h00ABCD00;
    send_frame(2'd1, 1'b0, 1'b0, 1'b0, 32'h1234, 16);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      si_valid = 1'b1;
      si_data  = fr2[23-k];
      if (k == 0) begin
        cfg_length = 2'd2; cfg_fill = 1'b1; cfg_msb = 1'b1; cfg_low = 1'b0;
        t0 = cyc;
        tests++;
        if (po_valid !== 1'b1 || po_data !== 16'h1234) begin
          fails++;
          $display("FAIL b2b_first: valid=%b data=%h, expected 1 1234", po_valid, po_data);
        end
      end else if (k == 5) begin
        cfg_length = 2'd0; cfg_msb = 1'b0;
      end
    end
    idle();
    tests++;
    if (po_valid !== 1'b1 || po_data !== 16'hABCD || pad_err !== 1'b0 || cyc - t0 !== 24) begin
      fails++;
      $display("FAIL b2b_second: valid=%b data=%h perr=%b gap=%0d, expected 1 abcd 0 24",
               po_valid, po_data, pad_err, cyc - t0);
    end
    idle();
  endtask

  task automatic test_pad();
    send_frame(2'd3, 1'b0, 1'b1, 1'b0, 32'h80000001, 32);
    idle();
    tests++;
    if (po_valid !== 1'b1 || po_data !== 16'h0001 || pad_err !== 1'b1) begin
      fails++;
      $display("FAIL pad_check: valid=%b data=%h perr=%b, expected 1 0001 1", po_valid, po_data, pad_err);
    end
    tests++;
    if (po_valid2 !== 1'b1 || po_data2 !== 16'h0001 || pad_err2 !== 1'b0) begin
      fails++;
      $display("FAIL pad_nocheck: valid=%b data=%h perr=%b, expected 1 0001 0", po_valid2, po_data2, pad_err2);
    end
    idle();
    tests++;
    if (pad_err !== 1'b0) begin fails++; $display("FAIL pad_strobe_width: perr=%b expected 0", pad_err); end
  endtask

  task automatic test_frame_err();
    send_frame(2'd1, 1'b0, 1'b1, 1'b0, 32'h5A3C, 16);
    idle();
    send_frame(2'd1, 1'b0, 1'b0, 1'b0, 32'hFFFF, 10);
    idle();
    @(negedge clk);
    tests++;
    if (frame_err !== 1'b1 || po_valid !== 1'b0 || po_data !== 16'h5A3C || busy !== 1'b0) begin
      fails++;
      $display("FAIL trunc: ferr=%b valid=%b data=%h busy=%b, expected 1 0 5a3c 0",
               frame_err, po_valid, po_data, busy);
    end
    @(negedge clk);
    tests++;
    if (frame_err !== 1'b0 || po_valid !== 1'b0) begin
      fails++;
      $display("FAIL trunc_width: ferr=%b valid=%b, expected 0 0", frame_err, po_valid);
    end
    send_frame(2'd1, 1'b0, 1'b0, 1'b0, 32'hC0DE, 16);
    idle();
    tests++;
    if (po_valid !== 1'b1 || po_data !== 16'hC0DE || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL after_trunc: valid=%b data=%h ferr=%b, expected 1 c0de 0", po_valid, po_data, frame_err);
    end
    idle();
  endtask

  task automatic test_reset_midframe();
    logic seen;
    seen = 1'b0;
    send_frame(2'd2, 1'b1, 1'b1, 1'b0, 32'h00FFFFFF, 12);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({po_data, po_valid, frame_err, pad_err, busy} !== 20'h0) begin
      fails++;
      $display("FAIL reset_mid: data=%h valid=%b ferr=%b perr=%b busy=%b, expected all 0",
               po_data, po_valid, frame_err, pad_err, busy);
    end
    reset = 1'b0; si_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (po_valid !== 1'b0 || frame_err !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL reset_mid_strobe: strobe seen=%b expected 0", seen); end
    send_frame(2'd0, 1'b0, 1'b1, 1'b1, 32'h3C, 8);
    idle();
    tests++;
    if (po_valid !== 1'b1 || po_data !== 16'h3C00) begin
      fails++;
      $display("FAIL after_reset: valid=%b data=%h, expected 1 3c00", po_valid, po_data);
    end
    idle();
  endtask

  task automatic test_random();
    logic [1:0]  len;
    logic        fill, msb, low, ep;
    logic [15:0] payload, padv, ed;
    for (int i = 0; i < 40; i++) begin
      len     = 2'($urandom);
      fill    = 1'($urandom);
      msb     = 1'($urandom);
      low     = 1'($urandom);
      payload = 16'($urandom);
      padv    = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0;
      ed      = exp_data(len, low, payload);
      ep      = exp_pad(len, padv);
      send_frame(len, fill, msb, low, make_frame(len, fill, payload, padv), 8 * (int'(len) + 1));
      idle();
      tests++;
      if (po_valid !== 1'b1 || po_data !== ed || pad_err !== ep || frame_err !== 1'b0 ||
          po_data2 !== ed || pad_err2 !== 1'b0) begin
        fails++;
        $display("FAIL random[%0d] len=%0d fill=%b msb=%b low=%b: valid=%b data=%h perr=%b data2=%h perr2=%b, expected 1 %h %b %h 0",
                 i, len, fill, msb, low, po_valid, po_data, pad_err, po_data2, pad_err2, ed, ep, ed);
      end
      repeat ($urandom_range(0, 2)) idle();
    end
  endtask

  initial begin
    test_reset();
    test_byte_frames();
    test_back_to_back();
    test_pad();
    test_frame_err();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
